bus_master_arbiter: RTL and testbench
=====================================

Name: bus_master_arbiter

Overview:
- Two-master round-robin arbiter in front of the single master port of the system Bus.
- Master 0 is the CPU data-memory interface. Master 1 is a second initiator: an instruction-fetch path or DMA engine.
- Serialises their strobe/ack transactions onto the Bus, latches and returns read data, and optionally aborts hung slave accesses with an error ack.

Parameters:
TIMEOUT_CYCLES, 255, bus_stb_o cycles without bus_ack_i before abort (used only with the optional feature); legal range 2..2^CNT_W-1
CNT_W, 8, width of the timeout counter

Ports:
clk_i  in  1  single clock; bus clock domain
rst_i  in  1  reset, synchronous and active-high
m0_stb_i  in  1  master 0 request strobe; held until m0_ack_o
m0_we_i  in  1  master 0 write enable
m0_adr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_ack_o  out  1  master 0 one-cycle completion pulse
m0_err_o  out  1  master 0 timeout error, qualifies m0_ack_o
m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o  same as m0_*, for master 1
bus_stb_o  out  1  strobe to Bus master_stb_i
bus_we_o  out  1  to Bus master_we_i
bus_adr_o  out  32  to Bus master_adr_i
bus_dat_o  out  32  to Bus master_dat_i
bus_dat_i  in  32  from Bus master_dat_o
bus_ack_i  in  1  from Bus master_ack_o
grant_o  out  2  one-hot current owner; 00 when idle
busy_o  out  1  transaction in flight

Behaviour:
- All outputs are registered.
- Reset: every output is 0, FSM enters IDLE, and last_grant = 1 so master 0 wins the first tie.
- Reset mid-transfer abandons the transfer: no ack is issued and bus_stb_o drops on the cycle after rst_i is sampled.
- FSM has three states: IDLE, XFER, RELEASE.
- IDLE:
  - If any mN_stb_i is sampled high at edge N, choose the winner and enter XFER.
  - Winner on a single request: the requester.
  - Winner on both requests: the master != last_grant.
  - At N+1: bus_stb_o=1, grant_o one-hot, busy_o=1.
  - bus_we_o, bus_adr_o and bus_dat_o are captured from the winner at edge N and held constant for the whole transfer. Later changes on the master's inputs are ignored.
- XFER:
  - bus_stb_o stays high until bus_ack_i is sampled high at edge M.
  - At M+1: bus_stb_o=0, mX_ack_o=1 for exactly one cycle, mX_dat_o=bus_dat_i captured at M (reads and writes alike), mX_err_o=0, last_grant=X, state = RELEASE.
- RELEASE:
  - Lasts one cycle; no stb is sampled. The served master must drop stb in this cycle.
  - Next state is IDLE with grant_o=00 and busy_o=0.
- Minimum transaction: request at N, bus_ack_i at N+1, mX_ack_o at N+2, next grant able to start at N+3.
- With both masters requesting continuously, grants strictly alternate: 0,1,0,1...
- A master never waits more than one transaction of the other master plus its own.
- mN_dat_o holds its last value until that master's next ack. It is not cleared in idle.
- The ack and err of the non-granted master are always 0.
- bus_ack_i while in IDLE or RELEASE is ignored.
- The timeout counter exists only with the optional feature. It clears on XFER entry and counts each XFER cycle without bus_ack_i.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN
- Defined:
  - If the counter reaches TIMEOUT_CYCLES-1 while in XFER with bus_ack_i=0, then on the next edge: bus_stb_o=0, mX_ack_o=1, mX_err_o=1, mX_dat_o=32'h0000_0000, last_grant=X, state = RELEASE.
  - bus_ack_i arriving in the same cycle as the terminal count wins: normal completion, err=0.
- Undefined:
  - No counter is built; XFER waits indefinitely.
  - m0_err_o and m1_err_o are tied to 0.

Test Plan:
- m0 read at 0x0000_1000; slave acks 2 cycles after bus_stb_o with data 0x1234_5678 -> bus_adr_o=0x1000, bus_we_o=0; m0_ack_o is a one-cycle pulse with m0_dat_o=0x12345678; grant_o 01 -> 00; m1_ack_o stays 0.
- Both masters strobe on the same edge after reset; slave acks immediately -> m0 served first. Sequence: bus_stb_o at N+1, m0_ack_o at N+2, RELEASE, m1 bus_stb_o at N+4.
- Both masters request continuously for 6 transactions -> grant order 0,1,0,1,0,1; no starvation.
- m1 write of 0xCAFE_F00D to 0x8000_0010; m1 changes m1_dat_i mid-transfer -> bus_dat_o stays 0xCAFEF00D until ack; bus_we_o=1.
- BUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4; slave never acks -> bus_stb_o high for 4 cycles, then m0_ack_o=1, m0_err_o=1, m0_dat_o=0. Without the macro, bus_stb_o stays high.
- rst_i asserted 1 cycle into XFER -> next cycle all outputs 0 and no ack. After reset, a lone m1 request is granted normally.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter driving the single Bus master port.
// Optional hung-slave abort is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_master_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam int unsigned DATA_W = 32;

    if ((TIMEOUT_CYCLES < 2) || ((TIMEOUT_CYCLES >> CNT_W) != 0)) begin : g_bad_cfg
        $error("bus_master_arbiter: TIMEOUT_CYCLES must lie in 2..2**CNT_W-1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_XFER    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic [1:0]          r_grant;
    logic                r_busy;
    logic                r_bus_stb;
    logic                r_bus_we;
    logic [DATA_W-1:0]   r_bus_adr;
    logic [DATA_W-1:0]   r_bus_dat;
    logic [DATA_W-1:0]   r_m0_dat;
    logic [DATA_W-1:0]   r_m1_dat;
    logic                r_m0_ack;
    logic                r_m1_ack;

    logic                w_any_req;
    logic                w_winner;
    logic                w_win_we;
    logic [DATA_W-1:0]   w_win_adr;
    logic [DATA_W-1:0]   w_win_dat;
    logic                w_abort;
    logic                w_done;
    logic [DATA_W-1:0]   w_rdata;

    // Tie goes to the master that did not own the previous transfer.
    assign w_any_req = m0_stb_i | m1_stb_i;
    assign w_winner  = (m0_stb_i & m1_stb_i) ? ~r_last_grant : m1_stb_i;
    assign w_win_we  = w_winner ? m1_we_i  : m0_we_i;
    assign w_win_adr = w_winner ? m1_adr_i : m0_adr_i;
    assign w_win_dat = w_winner ? m1_dat_i : m0_dat_i;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_m0_err;
    logic             r_m1_err;

    // A slave ack in the terminal-count cycle takes priority over the abort.
    assign w_abort = ~bus_ack_i & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                end
                S_XFER: begin
                    if (w_done) begin
                        r_m0_err <= w_abort & ~r_owner;
                        r_m1_err <= w_abort &  r_owner;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_m0_err <= 1'b0;
                    r_m1_err <= 1'b0;
                end
            endcase
        end
    end

    assign m0_err_o = r_m0_err;
    assign m1_err_o = r_m1_err;
`else
    assign w_abort  = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    assign w_done  = bus_ack_i | w_abort;
    assign w_rdata = w_abort ? '0 : bus_dat_i;

    // Arbitration FSM with all bus/master outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_bus_stb    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_adr    <= '0;
            r_bus_dat    <= '0;
            r_m0_dat     <= '0;
            r_m1_dat     <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_XFER;
                        r_owner   <= w_winner;
                        r_grant   <= w_winner ? 2'b10 : 2'b01;
                        r_busy    <= 1'b1;
                        r_bus_stb <= 1'b1;
                        r_bus_we  <= w_win_we;
                        r_bus_adr <= w_win_adr;
                        r_bus_dat <= w_win_dat;
                    end
                end
                S_XFER: begin
                    if (w_done) begin
                        r_state      <= S_RELEASE;
                        r_bus_stb    <= 1'b0;
                        r_last_grant <= r_owner;
                        if (r_owner) begin
                            r_m1_ack <= 1'b1;
                            r_m1_dat <= w_rdata;
                        end else begin
                            r_m0_ack <= 1'b1;
                            r_m0_dat <= w_rdata;
                        end
                    end
                end
                S_RELEASE: begin
                    r_state  <= S_IDLE;
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_grant  <= 2'b00;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_dat_o  = r_m0_dat;
    assign m1_dat_o  = r_m1_dat;
    assign m0_ack_o  = r_m0_ack;
    assign m1_ack_o  = r_m1_ack;
    assign bus_stb_o = r_bus_stb;
    assign bus_we_o  = r_bus_we;
    assign bus_adr_o = r_bus_adr;
    assign bus_dat_o = r_bus_dat;
    assign grant_o   = r_grant;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter with a round-robin reference model.
module tb_bus_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_stb, m0_we, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        bus_stb_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    // Reference model: request snapshot per master, last owner, last returned data.
    int          checks;
    int          errors;
    int          last_g;
    logic        req_we  [2];
    logic [31:0] req_adr [2];
    logic [31:0] req_dat [2];
    logic [31:0] exp_dat [2];

    always #5 clk = ~clk;

    bus_master_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
        .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int m, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat;
        end else begin
            m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat;
        end
        req_we[m] = we; req_adr[m] = adr; req_dat[m] = dat;
    endtask

    // Single requester wins; on a tie the one that was not served last wins.
    function automatic int pick();
        if (m0_stb && m1_stb) return 1 - last_g;
        if (m1_stb) return 1;
        return 0;
    endfunction

    function automatic logic ack_of(input int m);
        return (m == 1) ? m1_ack_o : m0_ack_o;
    endfunction

    function automatic logic [31:0] dat_of(input int m);
        return (m == 1) ? m1_dat_o : m0_dat_o;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_stb"},   32'(bus_stb_o), 32'(0));
        chk({tag, "_grant"}, 32'(grant_o),   32'(0));
        chk({tag, "_busy"},  32'(busy_o),    32'(0));
        chk({tag, "_acks"},  32'({m1_ack_o, m0_ack_o}), 32'(0));
        chk({tag, "_errs"},  32'({m1_err_o, m0_err_o}), 32'(0));
        chk({tag, "_m0dat"}, m0_dat_o, 32'(0));
        chk({tag, "_m1dat"}, m1_dat_o, 32'(0));
        chk({tag, "_badr"},  bus_adr_o, 32'(0));
        chk({tag, "_bdat"},  bus_dat_o, 32'(0));
        chk({tag, "_bwe"},   32'(bus_we_o), 32'(0));
    endtask

    // Called at a negedge right after the request(s) were raised with the DUT idle.
    task automatic serve(input int m, input int delay, input logic [31:0] rdata);
        int waits;
        int o;
        o = 1 - m;
        @(negedge clk);
        waits = 1;
        while (!bus_stb_o && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("grant_latency", 32'(waits), 32'(1));
        chk("grant", 32'(grant_o), (m == 1) ? 32'(2) : 32'(1));
        chk("busy", 32'(busy_o), 32'(1));
        chk("bus_adr", bus_adr_o, req_adr[m]);
        chk("bus_we", 32'(bus_we_o), 32'(req_we[m]));
        chk("bus_dat", bus_dat_o, req_dat[m]);
        for (int i = 0; i < delay; i++) begin
            if (m == 0) begin
                m0_adr = $urandom; m0_dat = $urandom; m0_we = 1'($urandom);
            end else begin
                m1_adr = $urandom; m1_dat = $urandom; m1_we = 1'($urandom);
            end
            @(negedge clk);
            chk("hold_stb", 32'(bus_stb_o), 32'(1));
            chk("hold_adr", bus_adr_o, req_adr[m]);
            chk("hold_dat", bus_dat_o, req_dat[m]);
            chk("hold_we", 32'(bus_we_o), 32'(req_we[m]));
            chk("early_ack", 32'({m1_ack_o, m0_ack_o}), 32'(0));
        end
        bus_ack_i = 1'b1;
        bus_dat_i = rdata;
        @(negedge clk);
        bus_ack_i = 1'b0;
        bus_dat_i = $urandom;
        chk("ack", 32'(ack_of(m)), 32'(1));
        chk("other_ack", 32'(ack_of(o)), 32'(0));
        chk("err", 32'({m1_err_o, m0_err_o}), 32'(0));
        chk("rdata", dat_of(m), rdata);
        chk("other_dat", dat_of(o), exp_dat[o]);
        chk("stb_drop", 32'(bus_stb_o), 32'(0));
        exp_dat[m] = rdata;
        last_g = m;
        if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
        @(negedge clk);
        chk("ack_pulse", 32'({m1_ack_o, m0_ack_o}), 32'(0));
        chk("idle_grant", 32'(grant_o), 32'(0));
        chk("idle_busy", 32'(busy_o), 32'(0));
        chk("dat_hold", dat_of(m), rdata);
    endtask

    initial begin
        int hi;
        int w;
        checks = 0; errors = 0; last_g = 1;
        exp_dat[0] = '0; exp_dat[1] = '0;
        rst = 1'b1; bus_ack_i = 1'b0; bus_dat_i = '0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Simultaneous requests straight after reset: m0 first, then m1.
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, $urandom);
        set_req(1, 1'b1, 1'b1, 32'h0000_0200, $urandom);
        serve(pick(), 0, $urandom);
        serve(pick(), 0, $urandom);

        // m0 read with a two-cycle slave.
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, $urandom);
        serve(pick(), 2, 32'h1234_5678);

        // A stray bus ack while idle must not complete anything.
        bus_ack_i = 1'b1; bus_dat_i = $urandom;
        repeat (2) @(negedge clk);
        bus_ack_i = 1'b0;
        chk("idle_ack_ignored", 32'({m1_ack_o, m0_ack_o}), 32'(0));
        chk("idle_dat_kept", m0_dat_o, exp_dat[0]);
        chk("idle_stb", 32'(bus_stb_o), 32'(0));

        // Both masters requesting continuously for six transfers.
        set_req(0, 1'b1, 1'($urandom), $urandom, $urandom);
        set_req(1, 1'b1, 1'($urandom), $urandom, $urandom);
        for (int i = 0; i < 6; i++) begin
            w = pick();
            serve(w, int'($urandom_range(0, 3)), $urandom);
            if (i < 5) set_req(w, 1'b1, 1'($urandom), $urandom, $urandom);
        end
        m0_stb = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        chk("alt_last_owner_idle", 32'(grant_o), 32'(0));

        // m1 write whose data input changes mid-transfer; ack on terminal count.
        set_req(1, 1'b1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D);
        serve(pick(), 3, $urandom);

        // Reset one cycle into XFER abandons the transfer.
        set_req(0, 1'b1, 1'b1, $urandom, $urandom);
        @(negedge clk);
        chk("pre_rst_stb", 32'(bus_stb_o), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        last_g = 1; exp_dat[0] = '0; exp_dat[1] = '0;
        m0_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'(0));
        set_req(1, 1'b1, 1'b0, $urandom, $urandom);
        serve(pick(), 1, $urandom);

        // Slave never acks.
        set_req(0, 1'b1, 1'b0, $urandom, $urandom);
        @(negedge clk);
        hi = 0;
        while (bus_stb_o && hi < 30) begin
            hi++;
            @(negedge clk);
        end
`ifdef BUS_ARB_TIMEOUT_EN
        chk("to_len", 32'(hi), 32'(4));
        chk("to_ack", 32'(m0_ack_o), 32'(1));
        chk("to_err", 32'(m0_err_o), 32'(1));
        chk("to_dat", m0_dat_o, 32'(0));
        chk("to_other", 32'({m1_ack_o, m1_err_o}), 32'(0));
        m0_stb = 1'b0; exp_dat[0] = '0; last_g = 0;
        @(negedge clk);
        chk("to_pulse", 32'({m0_ack_o, m0_err_o}), 32'(0));
        chk("to_idle", 32'(grant_o), 32'(0));
`else
        chk("no_timeout_len", 32'(hi), 32'(30));
        chk("no_timeout_ack", 32'({m1_ack_o, m0_ack_o}), 32'(0));
        chk("no_timeout_err", 32'({m1_err_o, m0_err_o}), 32'(0));
        rst = 1'b1; m0_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
